// File: rtl/clk_div_pkg.sv
// clk_div_pkg: output mode encodings shared by the divider bank and its channels
package clk_div_pkg;
    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel; config writes are shadowed and applied at terminal count
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = 24,
    parameter int RST_HALF = 714_285
) (
    input  logic             clk_in,
    input  logic             rst_l,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    input  mode_e            wr_mode,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);
    logic [CNT_W-1:0] act_half, sh_half, cnt, eff, nxt_half;
    mode_e act_mode, sh_mode, nxt_mode;
    logic tc;
    // a write and a pending shadow never coexist: cfg_ready blocks writes while pending
    always_comb begin
        eff = (act_half == '0) ? CNT_W'(1) : act_half;
        tc = en && (cnt == eff - CNT_W'(1));
        nxt_half = wr ? wr_half : pending ? sh_half : act_half;
        nxt_mode = wr ? wr_mode : pending ? sh_mode : act_mode;
    end
    always_ff @(posedge clk_in or negedge rst_l) begin
        if (!rst_l) begin
            act_half <= CNT_W'(RST_HALF);
            sh_half <= CNT_W'(RST_HALF);
            act_mode <= MODE_SQUARE;
            sh_mode <= MODE_SQUARE;
            pending <= 1'b0;
            cnt <= '0;
            clk_out <= 1'b0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            clk_out <= 1'b0;
            tick <= 1'b0;
            pending <= 1'b0;
            act_half <= nxt_half;
            act_mode <= nxt_mode;
        end else if (tc) begin
            cnt <= '0;
            tick <= 1'b1;
            pending <= 1'b0;
            act_half <= nxt_half;
            act_mode <= nxt_mode;
            clk_out <= (nxt_mode != act_mode) ? 1'b0 : (nxt_mode == MODE_PULSE) ? 1'b1 : !clk_out;
        end else begin
            cnt <= cnt + CNT_W'(1);
            tick <= 1'b0;
            clk_out <= (act_mode == MODE_PULSE) ? 1'b0 : clk_out;
            if (wr) begin
                sh_half <= wr_half;
                sh_mode <= wr_mode;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/clk_divider_bank.sv
// clk_divider_bank: NUM_CH independent clock dividers sharing one configuration port
module clk_divider_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 24,
    parameter int RST_HALF = 714_285
) (
    input  logic                                        clk_in,
    input  logic                                        rst_l,
    input  logic [NUM_CH-1:0]                           ch_en,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                            cfg_half,
    input  logic                                        cfg_mode,
    output logic [NUM_CH-1:0]                           clk_out,
    output logic [NUM_CH-1:0]                           tick
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    logic [NUM_CH-1:0] pend, wr;
    // out-of-range channels match nothing, so they stay ready and their writes vanish
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
        clk_div_channel #(
            .CNT_W(CNT_W),
            .RST_HALF(RST_HALF)
        ) u_ch (
            .clk_in(clk_in),
            .rst_l(rst_l),
            .en(ch_en[g]),
            .wr(wr[g]),
            .wr_half(cfg_half),
            .wr_mode(mode_e'(cfg_mode)),
            .clk_out(clk_out[g]),
            .tick(tick[g]),
            .pending(pend[g])
        );
    end
endmodule

// File: tb/tb_clk_divider_bank.sv
// tb_clk_divider_bank: scoreboard of expected tick gaps/levels per channel, popped by a monitor
module tb_clk_divider_bank;
    logic clk_in = 1'b0;
    logic rst_l = 1'b0;
    logic [1:0] ch_en = '0;
    logic cfg_valid = 1'b0, cfg_ch = 1'b0, cfg_mode = 1'b0;
    logic [7:0] cfg_half = '0;
    logic cfg_ready;
    logic [1:0] clk_out, tick;
    logic [2:0] b_en = '0;
    logic b_valid = 1'b0, b_mode = 1'b0;
    logic [1:0] b_ch = '0;
    logic [7:0] b_half = '0;
    logic b_ready;
    logic [2:0] b_clk_out, b_tick;
    typedef struct {
        int   gap;
        logic co;
    } exp_t;
    exp_t q0[$], q1[$];
    int checks = 0, errors = 0, cyc = 0;
    int seen[2] = '{0, 0};
    int last[2] = '{0, 0};
    logic glitch_en = 1'b0, prev0 = 1'b0;

    clk_divider_bank #(.NUM_CH(2), .CNT_W(8), .RST_HALF(3)) dut (
        .clk_in(clk_in), .rst_l(rst_l), .ch_en(ch_en), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_mode(cfg_mode),
        .clk_out(clk_out), .tick(tick)
    );
    // three channels so that cfg_ch = 3 is representable and out of range
    clk_divider_bank #(.NUM_CH(3), .CNT_W(8), .RST_HALF(3)) dut_b (
        .clk_in(clk_in), .rst_l(rst_l), .ch_en(b_en), .cfg_valid(b_valid),
        .cfg_ready(b_ready), .cfg_ch(b_ch), .cfg_half(b_half), .cfg_mode(b_mode),
        .clk_out(b_clk_out), .tick(b_tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int gap, input logic co);
        if (c == 0) q0.push_back(exp_t'{gap, co});
        else q1.push_back(exp_t'{gap, co});
    endtask

    task automatic score(input int c, input exp_t e);
        if (e.gap != 0) check($sformatf("gap%0d", c), cyc - last[c], e.gap);
        check($sformatf("level%0d", c), int'(clk_out[c]), int'(e.co));
    endtask

    always begin
        exp_t e;
        @(posedge clk_in);
        #2;
        cyc++;
        if (tick[0]) begin
            check("tick0_expected", int'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                score(0, e);
            end
            last[0] = cyc;
            seen[0]++;
        end
        if (tick[1]) begin
            check("tick1_expected", int'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                score(1, e);
            end
            last[1] = cyc;
            seen[1]++;
        end
        if (glitch_en) check("glitch0", int'(clk_out[0] != prev0 && !tick[0]), 0);
        prev0 = clk_out[0];
    end

    task automatic wait_ticks(input int c, input int n);
        int target;
        target = seen[c] + n;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (seen[c] >= target) return;
        end
        check($sformatf("timeout%0d", c), seen[c], target);
    endtask

    task automatic cfg_write(input logic ch, input int half, input logic mode);
        cfg_valid = 1'b1;
        cfg_ch = ch;
        cfg_half = 8'(half);
        cfg_mode = mode;
        @(negedge clk_in);
        cfg_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        // half 3 from reset: toggles every 3 cycles
        push(0, 0, 1'b1); push(0, 3, 1'b0); push(0, 3, 1'b1); push(0, 3, 1'b0);
        rst_l = 1'b1;
        ch_en = 2'b01;
        glitch_en = 1'b1;
        wait_ticks(0, 4);
        check("ch1_idle", int'({clk_out[1], tick[1]}), 0);
        // mid-period write: old half finishes, then half 5
        check("ready_pre", int'(cfg_ready), 1);
        push(0, 3, 1'b1); push(0, 5, 1'b0); push(0, 5, 1'b1); push(0, 5, 1'b0);
        cfg_write(1'b0, 5, 1'b0);
        check("ready_pending", int'(cfg_ready), 0);
        wait_ticks(0, 1);
        check("ready_released", int'(cfg_ready), 1);
        wait_ticks(0, 3);
        // write landing exactly on the terminal-count edge
        push(0, 5, 1'b1); push(0, 2, 1'b0); push(0, 2, 1'b1);
        repeat (4) @(negedge clk_in);
        check("ready_tc_before", int'(cfg_ready), 1);
        cfg_write(1'b0, 2, 1'b0);
        check("ready_tc_after", int'(cfg_ready), 1);
        wait_ticks(0, 2);
        glitch_en = 1'b0;
        ch_en = 2'b00;
        @(negedge clk_in);
        check("ch0_disabled", int'({clk_out[0], tick[0]}), 0);
        // disabled ch1 takes half 0 in pulse mode immediately
        cfg_ch = 1'b1;
        check("ready_ch1", int'(cfg_ready), 1);
        cfg_write(1'b1, 0, 1'b1);
        check("ready_ch1_after", int'(cfg_ready), 1);
        push(1, 0, 1'b1);
        for (int i = 0; i < 5; i++) push(1, 1, 1'b1);
        ch_en = 2'b10;
        wait_ticks(1, 6);
        ch_en = 2'b00;
        @(negedge clk_in);
        check("ch1_disabled", int'({clk_out[1], tick[1]}), 0);
        // reset with an update pending on ch0
        cfg_ch = 1'b0;
        push(0, 0, 1'b1);
        ch_en = 2'b01;
        wait_ticks(0, 1);
        cfg_write(1'b0, 7, 1'b0);
        check("ready_pend_rst", int'(cfg_ready), 0);
        check("clk_out_pre_rst", int'(clk_out[0]), 1);
        #2 rst_l = 1'b0;
        #1;
        check("async_clk_out", int'(clk_out), 0);
        check("async_tick", int'(tick), 0);
        check("async_ready", int'(cfg_ready), 1);
        repeat (2) @(negedge clk_in);
        push(0, 0, 1'b1); push(0, 3, 1'b0); push(0, 3, 1'b1);
        rst_l = 1'b1;
        check("ready_post_rst", int'(cfg_ready), 1);
        wait_ticks(0, 3);
        ch_en = 2'b00;
        // out-of-range write must not touch any channel
        b_ch = 2'd3;
        check("b_ready_oor", int'(b_ready), 1);
        b_valid = 1'b1;
        b_half = 8'd1;
        b_mode = 1'b1;
        @(negedge clk_in);
        b_valid = 1'b0;
        check("b_ready_after", int'(b_ready), 1);
        b_en = 3'b111;
        @(negedge clk_in);
        check("b_tick_e1", int'(b_tick), 0);
        @(negedge clk_in);
        check("b_tick_e2", int'(b_tick), 0);
        @(negedge clk_in);
        check("b_tick_e3", int'(b_tick), 7);
        check("b_clk_out_e3", int'(b_clk_out), 7);
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
